// File: rtl/ring_counter_param_pkg.sv
// ring_counter_param_pkg
// Shared constants and helpers for the parametrised ring/Johnson counter.
//   MODE_RING / MODE_JOHNSON : values of Mode_In
//   DIR_TO_LSB / DIR_TO_MSB  : values of Dir_In
//   seed_value(width)        : counter seed (MSB set, all other bits clear),
//                              returned in a MAX_WIDTH-wide vector; callers
//                              size-cast it down to their own width.
package ring_counter_param_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  localparam logic DIR_TO_LSB = 1'b0;
  localparam logic DIR_TO_MSB = 1'b1;

  function automatic logic [MAX_WIDTH-1:0] seed_value(input int unsigned width);
    logic [MAX_WIDTH-1:0] s;
    s = '0;
    s[width-1] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/ring_counter_param_check.sv
// ring_state_check
// Combinational legality check of a counter state.
//   state         : current counter value (WIDTH bits)
//   ring_legal    : exactly one bit set
//   johnson_legal : MSB-first pattern 1^k 0^(W-k) or 0^k 1^(W-k)
module ring_state_check #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] state,
  output logic             ring_legal,
  output logic             johnson_legal
);

  // One bit per adjacent pair of state bits, set where the pair differs.
  // A Johnson state has at most one such 0/1 boundary.
  logic [WIDTH-2:0] edges;

  assign edges = state[WIDTH-1:1] ^ state[WIDTH-2:0];

  // x & (x - 1) clears the lowest set bit, so a zero result means
  // "at most one bit set".
  assign ring_legal    = (state != '0) &&
                         ((state & (state - WIDTH'(1))) == '0);
  assign johnson_legal = ((edges & (edges - (WIDTH-1)'(1))) == '0);

endmodule

// File: rtl/ring_counter_param.sv
// ring_counter_param
// Parametrised shift-register counter: ring (one-hot) or Johnson mode,
// either shift direction, parallel load, illegal-state self-correction.
// All registers update on the falling edge of Clk_In.
//   Clk_In         : clock (falling edge active)
//   Reset_In       : asynchronous active-high reset -> Count_Out = SEED
//   Start_Stopb_In : 1 = advance each edge, 0 = hold
//   Mode_In        : 0 = ring, 1 = Johnson
//   Dir_In         : 0 = shift toward LSB, 1 = shift toward MSB
//   Load_In        : parallel load, higher priority than advance
//   Load_Data_In   : value loaded (taken verbatim, even if illegal)
//   Count_Out      : counter state
//   Wrap_Out       : one-cycle pulse after a legal advance landing on SEED
//   Fault_Out      : one-cycle pulse after an advance that corrected an
//                    illegal state back to SEED
// There is no handshake: every input is sampled on every falling edge.
module ring_counter_param
  import ring_counter_param_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Start_Stopb_In,
  input  logic             Mode_In,
  input  logic             Dir_In,
  input  logic             Load_In,
  input  logic [WIDTH-1:0] Load_Data_In,
  output logic [WIDTH-1:0] Count_Out,
  output logic             Wrap_Out,
  output logic             Fault_Out
);

  localparam logic [WIDTH-1:0] SEED = WIDTH'(seed_value(WIDTH));

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             fault_q;

  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic             fault_d;

  logic [WIDTH-1:0] shifted;
  logic             ring_legal;
  logic             johnson_legal;
  logic             state_legal;

  ring_state_check #(.WIDTH(WIDTH)) u_check (
    .state         (count_q),
    .ring_legal    (ring_legal),
    .johnson_legal (johnson_legal)
  );

  // Legality is judged against the mode presented on this edge, so a mode
  // change can make the held state illegal and trigger a correction.
  assign state_legal = (Mode_In == MODE_JOHNSON) ? johnson_legal : ring_legal;

  // Johnson differs from ring only in inverting the bit fed back in.
  always_comb begin
    shifted = count_q;
    if (Dir_In == DIR_TO_LSB) begin
      if (Mode_In == MODE_JOHNSON) shifted = {~count_q[0], count_q[WIDTH-1:1]};
      else                         shifted = { count_q[0], count_q[WIDTH-1:1]};
    end else begin
      if (Mode_In == MODE_JOHNSON) shifted = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
      else                         shifted = {count_q[WIDTH-2:0],  count_q[WIDTH-1]};
    end
  end

  // Priority: load > advance > hold.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    fault_d = 1'b0;
    if (Load_In) begin
      count_d = Load_Data_In;
    end else if (Start_Stopb_In) begin
      if (state_legal) begin
        count_d = shifted;
        wrap_d  = (shifted == SEED);
      end else begin
        count_d = SEED;
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      count_q <= SEED;
      wrap_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      fault_q <= fault_d;
    end
  end

  assign Count_Out = count_q;
  assign Wrap_Out  = wrap_q;
  assign Fault_Out = fault_q;

endmodule

// File: tb/tb_ring_counter_param.sv
// tb_ring_counter_param
// Self-checking bench for ring_counter_param at WIDTH = 8. Expected values
// come from a sequence-table model: the legal states of each mode are listed
// in counting order starting at SEED, an advance moves one index forward
// (toward LSB) or backward (toward MSB), and a state missing from the table
// of the current mode is illegal.
module tb_ring_counter_param;

  localparam int W = 8;
  localparam logic [W-1:0] SEED = 8'h80;

  logic         Clk_In;
  logic         Reset_In;
  logic         Start_Stopb_In;
  logic         Mode_In;
  logic         Dir_In;
  logic         Load_In;
  logic [W-1:0] Load_Data_In;
  logic [W-1:0] Count_Out;
  logic         Wrap_Out;
  logic         Fault_Out;

  ring_counter_param #(.WIDTH(W)) dut (
    .Clk_In         (Clk_In),
    .Reset_In       (Reset_In),
    .Start_Stopb_In (Start_Stopb_In),
    .Mode_In        (Mode_In),
    .Dir_In         (Dir_In),
    .Load_In        (Load_In),
    .Load_Data_In   (Load_Data_In),
    .Count_Out      (Count_Out),
    .Wrap_Out       (Wrap_Out),
    .Fault_Out      (Fault_Out)
  );

  // ---------------- clock / reset ----------------
  initial Clk_In = 1'b0;
  always #5 Clk_In = ~Clk_In;

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0] rtab [W];
  logic [W-1:0] jtab [2*W];
  logic [W-1:0] m;
  logic         ew;
  logic         ef;
  logic [W+1:0] exp_q [$];   // {count, wrap, fault} per edge
  int           chk_cnt;
  int           pass_cnt;

  task automatic build_tables();
    logic [W-1:0] ones;
    ones = '1;
    for (int i = 0; i < W; i++) rtab[i] = SEED >> i;
    for (int i = 0; i < W; i++) jtab[i] = ~(ones >> (i + 1));
    for (int i = W; i < 2*W; i++) jtab[i] = ones >> (i - W + 1);
  endtask

  function automatic int find_idx(input logic md, input logic [W-1:0] v);
    int n;
    n = md ? 2*W : W;
    for (int i = 0; i < n; i++) begin
      if (md && jtab[i] == v) return i;
      if (!md && rtab[i] == v) return i;
    end
    return -1;
  endfunction

  // ---------------- driver ----------------
  // Drives one edge's inputs, waits for the falling edge, advances the model
  // and queues the expected outputs; callers pop and compare.
  task automatic do_edge(input logic ld, input logic [W-1:0] d, input logic st,
                         input logic md, input logic dr);
    int idx;
    int n;
    Load_In = ld; Load_Data_In = d; Start_Stopb_In = st; Mode_In = md; Dir_In = dr;
    @(negedge Clk_In);
    ew = 1'b0;
    ef = 1'b0;
    if (ld) begin
      m = d;
    end else if (st) begin
      idx = find_idx(md, m);
      if (idx < 0) begin
        m  = SEED;
        ef = 1'b1;
      end else begin
        n   = md ? 2*W : W;
        idx = dr ? (idx + n - 1) % n : (idx + 1) % n;
        m   = md ? jtab[idx] : rtab[idx];
        ew  = (idx == 0);
      end
    end
    exp_q.push_back({m, ew, ef});
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Load_In = 0; Load_Data_In = '0; Start_Stopb_In = 0; Mode_In = 0; Dir_In = 0;
    Reset_In = 1'b0;
    #1 Reset_In = 1'b1;
    #2;
    m = SEED;
    chk_cnt++;
    if ({Count_Out, Wrap_Out, Fault_Out} !== {SEED, 1'b0, 1'b0})
      $display("FAIL reset: got %h/%b/%b expected %h/0/0", Count_Out, Wrap_Out, Fault_Out, SEED);
    else pass_cnt++;
    #4 Reset_In = 1'b0;
  endtask

  task automatic test_ring_seq();
    logic [W+1:0] e;
    for (int i = 1; i <= W; i++) begin
      do_edge(0, '0, 1, 0, 0);
      e = exp_q.pop_front();
      chk_cnt++;
      if ({Count_Out, Wrap_Out, Fault_Out} !== e)
        $display("FAIL ring_seq step %0d: got %h/%b/%b expected %h/%b/%b",
                 i, Count_Out, Wrap_Out, Fault_Out, e[W+1:2], e[1], e[0]);
      else pass_cnt++;
      chk_cnt++;
      if (Count_Out !== (SEED >> (i % W)))
        $display("FAIL ring_seq_const step %0d: got %h expected %h", i, Count_Out, SEED >> (i % W));
      else pass_cnt++;
    end
  endtask

  task automatic test_johnson_seq();
    logic [W+1:0] e;
    logic [W-1:0] jref [16];
    jref = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h7F,
             8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h80};
    for (int i = 0; i < 2*W; i++) begin
      do_edge(0, '0, 1, 1, 0);
      e = exp_q.pop_front();
      chk_cnt++;
      if ({Count_Out, Wrap_Out, Fault_Out} !== e)
        $display("FAIL johnson_seq step %0d: got %h/%b/%b expected %h/%b/%b",
                 i + 1, Count_Out, Wrap_Out, Fault_Out, e[W+1:2], e[1], e[0]);
      else pass_cnt++;
      chk_cnt++;
      if (Count_Out !== jref[i] || Wrap_Out !== (i == 2*W-1))
        $display("FAIL johnson_seq_const step %0d: got %h/%b expected %h/%b",
                 i + 1, Count_Out, Wrap_Out, jref[i], (i == 2*W-1));
      else pass_cnt++;
    end
  endtask

  task automatic test_dir_reversal();
    logic [W+1:0] e;
    logic [W-1:0] want [5];
    want = '{8'h01, 8'h02, 8'h00, 8'h01, 8'h03};
    do_edge(1, SEED, 0, 0, 1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        do_edge(1, SEED, 0, 1, 1);
        void'(exp_q.pop_front());
      end
      do_edge(0, '0, 1, (i >= 2), 1);
      e = exp_q.pop_front();
      chk_cnt++;
      if ({Count_Out, Wrap_Out, Fault_Out} !== e || Count_Out !== want[i])
        $display("FAIL dir_reversal step %0d: got %h/%b/%b expected %h/%b/%b",
                 i, Count_Out, Wrap_Out, Fault_Out, want[i], e[1], e[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_illegal_recovery();
    logic [W+1:0] e;
    // ring: load 00, advance; johnson: load 5A, hold twice, advance
    do_edge(1, 8'h00, 0, 0, 0); void'(exp_q.pop_front());
    do_edge(0, '0, 1, 0, 0);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({Count_Out, Wrap_Out, Fault_Out} !== e || {Count_Out, Wrap_Out, Fault_Out} !== {SEED, 2'b01})
      $display("FAIL ring_illegal: got %h/%b/%b expected 80/0/1", Count_Out, Wrap_Out, Fault_Out);
    else pass_cnt++;
    do_edge(1, 8'h5A, 0, 1, 0); void'(exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      do_edge(0, '0, 0, 1, 0);
      e = exp_q.pop_front();
      chk_cnt++;
      if ({Count_Out, Wrap_Out, Fault_Out} !== e || Count_Out !== 8'h5A || Fault_Out !== 1'b0)
        $display("FAIL illegal_hold %0d: got %h/%b/%b expected 5a/0/0", i, Count_Out, Wrap_Out, Fault_Out);
      else pass_cnt++;
    end
    do_edge(0, '0, 1, 1, 0);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({Count_Out, Wrap_Out, Fault_Out} !== e || {Count_Out, Wrap_Out, Fault_Out} !== {SEED, 2'b01})
      $display("FAIL johnson_illegal: got %h/%b/%b expected 80/0/1", Count_Out, Wrap_Out, Fault_Out);
    else pass_cnt++;
  endtask

  task automatic test_mode_switch();
    logic [W+1:0] e;
    // ring 80 -> 40, then Johnson advance from 40 (illegal there)
    do_edge(1, SEED, 0, 0, 0); void'(exp_q.pop_front());
    do_edge(0, '0, 1, 0, 0);   void'(exp_q.pop_front());
    do_edge(0, '0, 1, 1, 0);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({Count_Out, Wrap_Out, Fault_Out} !== e || Fault_Out !== 1'b1)
      $display("FAIL mode_switch_40: got %h/%b/%b expected %h/%b/%b",
               Count_Out, Wrap_Out, Fault_Out, e[W+1:2], e[1], e[0]);
    else pass_cnt++;
    // ring at 01 is also a Johnson state: advances continue without fault
    do_edge(1, 8'h01, 0, 0, 0); void'(exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      do_edge(0, '0, 1, 1, 0);
      e = exp_q.pop_front();
      chk_cnt++;
      if ({Count_Out, Wrap_Out, Fault_Out} !== e || Fault_Out !== 1'b0)
        $display("FAIL mode_switch_01 step %0d: got %h/%b/%b expected %h/%b/%b",
                 i, Count_Out, Wrap_Out, Fault_Out, e[W+1:2], e[1], e[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_load_stop();
    logic [W+1:0] e;
    do_edge(1, 8'h3C, 1, 0, 0);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({Count_Out, Wrap_Out, Fault_Out} !== e || Count_Out !== 8'h3C)
      $display("FAIL load_priority: got %h/%b/%b expected 3c/0/0", Count_Out, Wrap_Out, Fault_Out);
    else pass_cnt++;
    do_edge(1, SEED, 0, 0, 0);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({Count_Out, Wrap_Out, Fault_Out} !== e || Wrap_Out !== 1'b0)
      $display("FAIL load_seed_nowrap: got %h/%b/%b expected 80/0/0", Count_Out, Wrap_Out, Fault_Out);
    else pass_cnt++;
    do_edge(0, '0, 1, 0, 0); void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      do_edge(0, 8'hFF, 0, i[0], i[1]);
      e = exp_q.pop_front();
      chk_cnt++;
      if ({Count_Out, Wrap_Out, Fault_Out} !== e || Count_Out !== 8'h40)
        $display("FAIL stop_hold %0d: got %h/%b/%b expected 40/0/0", i, Count_Out, Wrap_Out, Fault_Out);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    logic [W+1:0] e;
    do_edge(1, SEED, 0, 0, 0); void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      do_edge(0, '0, 1, 0, 0); void'(exp_q.pop_front());
    end
    chk_cnt++;
    if (Count_Out !== 8'h10)
      $display("FAIL async_reset_pre: got %h expected 10", Count_Out);
    else pass_cnt++;
    #3 Reset_In = 1'b1;
    #1;
    m = SEED;
    chk_cnt++;
    if ({Count_Out, Wrap_Out, Fault_Out} !== {SEED, 2'b00})
      $display("FAIL async_reset: got %h/%b/%b expected 80/0/0", Count_Out, Wrap_Out, Fault_Out);
    else pass_cnt++;
    #1 Reset_In = 1'b0;
    do_edge(0, '0, 1, 0, 0);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({Count_Out, Wrap_Out, Fault_Out} !== e)
      $display("FAIL async_reset_resume: got %h/%b/%b expected %h/%b/%b",
               Count_Out, Wrap_Out, Fault_Out, e[W+1:2], e[1], e[0]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W+1:0] e;
    logic         ld, st, md, dr;
    logic [W-1:0] d;
    md = 0; dr = 0;
    for (int i = 0; i < 300; i++) begin
      ld = ($urandom_range(0, 11) == 0);
      st = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) md = ~md;
      if ($urandom_range(0, 15) == 0) dr = ~dr;
      d = ($urandom_range(0, 1) == 0) ? W'($urandom) : jtab[$urandom_range(0, 2*W-1)];
      do_edge(ld, d, st, md, dr);
      e = exp_q.pop_front();
      chk_cnt++;
      if ({Count_Out, Wrap_Out, Fault_Out} !== e)
        $display("FAIL random cycle %0d: got %h/%b/%b expected %h/%b/%b",
                 i, Count_Out, Wrap_Out, Fault_Out, e[W+1:2], e[1], e[0]);
      else pass_cnt++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    build_tables();
    test_reset();
    test_ring_seq();
    test_johnson_seq();
    test_dir_reversal();
    test_illegal_recovery();
    test_mode_switch();
    test_load_stop();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
